gpr_file_mp: RTL
================

// Module: gpr_file_mp
// PURPOSE
//   Parametrised general-purpose register file: two registered read ports and one write port, usable in the same cycle.
//   Adds write-to-read bypass, optional hardwired-zero register 0, a per-register pending-write scoreboard and a sequenced bulk-clear engine.
//   Sits between decode (reads, reservations) and writeback (writes) in the CPU datapath.
// PARAMETERS
//   DATA_W   8  register width in bits
//   ADDR_W   3  register index width; DEPTH = 2**ADDR_W registers
//   ZERO_REG 0  1: register 0 always reads 0, writes/reservations to it ignored
// PORTS
//   clk       in   1       clock, all state on rising edge
//   rst_n     in   1       asynchronous active-low reset
//   rd_en     in   1       capture both read ports this cycle
//   ra_addr   in   ADDR_W  read port A index
//   rb_addr   in   ADDR_W  read port B index
//   ra_data   out  DATA_W  port A data, registered
//   rb_data   out  DATA_W  port B data, registered
//   ra_busy   out  1       scoreboard bit of ra_addr, captured with ra_data
//   rb_busy   out  1       scoreboard bit of rb_addr, captured with rb_data
//   rd_valid  out  1       1-cycle pulse: read data/busy updated
//   wr_en     in   1       write wc_data to wc_addr; clears its busy bit
//   wc_addr   in   ADDR_W  write index
//   wc_data   in   DATA_W  write data
//   resv_en   in   1       set busy bit of resv_addr (pending write)
//   resv_addr in   ADDR_W  reservation index
//   clr_start in   1       start bulk clear (sampled in IDLE only)
//   clr_busy  out  1       high while clear engine runs
// BEHAVIOUR
//   - Reset (async, rst_n=0): all registers 0, all busy bits 0, ra/rb_data=0, ra/rb_busy=0, rd_valid=0, FSM=IDLE, clr_busy=0.
//   - Read: rd_en at edge N -> ra/rb_data, ra/rb_busy valid after edge N, rd_valid=1 for exactly that cycle; outputs hold when rd_en=0.
//   - Write-first bypass: wr_en && wc_addr==ra_addr in the rd_en cycle -> ra_data=wc_data (same for B).
//   - Both read ports may address the same register; each is resolved independently.
//   - Captured busy = next-state busy bit: reservation sets, write clears; resv_en and wr_en to same index -> set wins (bit=1).
//   - ZERO_REG=1: index 0 reads data 0, busy 0, even under bypass; writes/reservations to 0 discarded.
//   - FSM IDLE: clr_start=1 -> CLEAR next cycle, ptr=0. Same-cycle wr_en/resv_en/rd_en still executed.
//   - FSM CLEAR: each cycle reg[ptr]=0, busy[ptr]=0, ptr++; at ptr==DEPTH-1 -> IDLE. clr_busy=1 for exactly DEPTH cycles.
//   - In CLEAR: wr_en, resv_en, rd_en, clr_start ignored; rd_valid stays 0; data/busy outputs hold.
//   - Reset during CLEAR: immediate IDLE, everything zero; no resume.
//   - ptr is ADDR_W bits; no wrap beyond DEPTH-1.
// TESTING
//   1. Reset, rd_en ra=3 rb=5 -> next cycle ra_data=0, rb_data=0, rd_valid=1 for one cycle.
//   2. wr_en r3=0xA5 with rd_en ra=3 same cycle -> ra_data=0xA5 next cycle (bypass); rd_en rb=3 later -> rb_data=0xA5.
//   3. resv_en r2; rd_en ra=2 -> ra_busy=1; wr_en r2=0x11 -> busy cleared; resv_en+wr_en r4 same cycle -> rb_busy(4)=1.
//   4. ZERO_REG=1: wr_en r0=0xFF, resv_en r0, rd_en ra=0 -> ra_data=0, ra_busy=0.
//   5. Load r1..r7 nonzero, clr_start -> clr_busy high 8 cycles; wr_en/rd_en in that window ignored; then all reads 0, busy 0.
//   6. rst_n low mid-CLEAR (cycle 3) -> clr_busy=0 at once, all outputs 0; release, rd_en -> all registers read 0.

Source files
------------

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: two registered read ports, one write port, bypass,
// pending-write scoreboard and a sequenced bulk-clear engine.
module gpr_file_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wc_addr,
    input  logic [DATA_W-1:0] wc_data,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic              clr_start,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_busy_q, clr_busy_d;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic [DATA_W-1:0] ra_data_q, ra_data_d;
    logic [DATA_W-1:0] rb_data_q, rb_data_d;
    logic              ra_busy_q, ra_busy_d;
    logic              rb_busy_q, rb_busy_d;
    logic              rd_valid_q, rd_valid_d;

    logic              zero_en;
    logic              wr_ok;
    logic              rs_ok;

    assign zero_en = (ZERO_REG != 0);
    assign wr_ok   = wr_en && !(zero_en && wc_addr == '0);
    assign rs_ok   = resv_en && !(zero_en && resv_addr == '0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_busy_d = clr_busy_q;
        regs_d     = regs_q;
        busy_d     = busy_q;
        ra_data_d  = ra_data_q;
        rb_data_d  = rb_data_q;
        ra_busy_d  = ra_busy_q;
        rb_busy_d  = rb_busy_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    regs_d[wc_addr] = wc_data;
                    busy_d[wc_addr] = 1'b0;
                end
                // Reservation after the write so a same-index pair stays busy
                if (rs_ok) begin
                    busy_d[resv_addr] = 1'b1;
                end

                if (rd_en) begin
                    rd_valid_d = 1'b1;

                    ra_data_d = regs_q[ra_addr];
                    if (wr_ok && wc_addr == ra_addr) begin
                        ra_data_d = wc_data;
                    end
                    ra_busy_d = busy_d[ra_addr];
                    if (zero_en && ra_addr == '0) begin
                        ra_data_d = '0;
                        ra_busy_d = 1'b0;
                    end

                    rb_data_d = regs_q[rb_addr];
                    if (wr_ok && wc_addr == rb_addr) begin
                        rb_data_d = wc_data;
                    end
                    rb_busy_d = busy_d[rb_addr];
                    if (zero_en && rb_addr == '0) begin
                        rb_data_d = '0;
                        rb_busy_d = 1'b0;
                    end
                end

                if (clr_start) begin
                    state_d    = CLEAR;
                    ptr_d      = '0;
                    clr_busy_d = 1'b1;
                end
            end

            CLEAR: begin
                regs_d[ptr_q] = '0;
                busy_d[ptr_q] = 1'b0;
                ptr_d         = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d    = IDLE;
                    ptr_d      = '0;
                    clr_busy_d = 1'b0;
                end
            end

            default: begin
                state_d    = IDLE;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
            busy_q     <= '0;
            ra_data_q  <= '0;
            rb_data_q  <= '0;
            ra_busy_q  <= 1'b0;
            rb_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_busy_q <= clr_busy_d;
            busy_q     <= busy_d;
            ra_data_q  <= ra_data_d;
            rb_data_q  <= rb_data_d;
            ra_busy_q  <= ra_busy_d;
            rb_busy_q  <= rb_busy_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ra_data  = ra_data_q;
    assign rb_data  = rb_data_q;
    assign ra_busy  = ra_busy_q;
    assign rb_busy  = rb_busy_q;
    assign rd_valid = rd_valid_q;
    assign clr_busy = clr_busy_q;

endmodule
